// File: rtl/vx_local_mem_pkg.sv
// Shared types, default widths and width helpers for the local memory arbiter.
package vx_local_mem_pkg;

  localparam int DEF_NUM_REQS        = 2;
  localparam int DEF_ADDR_WIDTH      = 26;
  localparam int DEF_DATA_WIDTH      = 512;
  localparam int DEF_TAG_WIDTH       = 56;
  localparam int DEF_MAX_OUTSTANDING = 8;

  // Width of a requester index; never less than one bit.
  function automatic int idx_width(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  // Width of a counter that must hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_NUM_REQS);

  // Memory-side request as seen at the default configuration.
  typedef struct packed {
    logic                               rw;
    logic [DEF_DATA_WIDTH/8-1:0]        byteen;
    logic [DEF_ADDR_WIDTH-1:0]          addr;
    logic [DEF_DATA_WIDTH-1:0]          data;
    logic [DEF_TAG_WIDTH+DEF_IDX_W-1:0] tag;
  } mem_req_t;

  // Memory-side response as seen at the default configuration.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]          data;
    logic [DEF_TAG_WIDTH+DEF_IDX_W-1:0] tag;
  } mem_rsp_t;

endpackage

// File: rtl/vx_local_mem_arbiter_chk.sv
// Protocol checks for the local memory arbiter.
module vx_local_mem_arbiter_chk #(
  parameter int NUM_REQS = 2,
  parameter int REQ_W    = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                mem_req_valid_i,
  input logic                mem_req_ready_i,
  input logic [REQ_W-1:0]    mem_req_bits_i,
  input logic                mem_rsp_fire_i,
  input logic                mem_rsp_in_range_i,
  input logic [NUM_REQS-1:0] cnt_dec_i,
  input logic [NUM_REQS-1:0] cnt_zero_i
);

  a_req_hold : assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_req_valid_i && !mem_req_ready_i) |=> (mem_req_valid_i && $stable(mem_req_bits_i)));

  a_cnt_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(|(cnt_dec_i & cnt_zero_i)));

  a_rsp_index : assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rsp_fire_i |-> mem_rsp_in_range_i);

endmodule

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index and wraps.
module vx_rr_arbiter
  import vx_local_mem_pkg::*;
#(
  parameter  int NUM_REQS = 2,
  localparam int IDX_W    = idx_width(NUM_REQS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQS-1:0] valid_i,
  input  logic                advance_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic                grant_any_o
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic             hi_hit_s;
  logic [IDX_W-1:0] hi_idx_s;
  logic [IDX_W-1:0] lo_idx_s;

  // Lowest valid index above the pointer wins, otherwise lowest valid overall.
  always_comb begin
    hi_hit_s    = 1'b0;
    hi_idx_s    = '0;
    lo_idx_s    = '0;
    grant_any_o = 1'b0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (valid_i[i] && (IDX_W'(i) > last_q)) begin
        hi_hit_s = 1'b1;
        hi_idx_s = IDX_W'(i);
      end else begin
      end
      if (valid_i[i]) begin
        grant_any_o = 1'b1;
        lo_idx_s    = IDX_W'(i);
      end else begin
      end
    end
    grant_idx_o = hi_hit_s ? hi_idx_s : lo_idx_s;
    for (int i = 0; i < NUM_REQS; i++) begin
      grant_o[i] = grant_any_o && (grant_idx_o == IDX_W'(i));
    end
    last_d = (advance_i && grant_any_o) ? grant_idx_o : last_q;
  end

  // Pointer starts at the top index so the first search favours index 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= IDX_W'(NUM_REQS - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/vx_local_mem_arbiter.sv
// Shares one local memory port between NUM_REQS requesters with round-robin
// arbitration, tag-based response routing and per-requester read caps.
module vx_local_mem_arbiter
  import vx_local_mem_pkg::*;
#(
  parameter  int NUM_REQS        = DEF_NUM_REQS,
  parameter  int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter  int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter  int TAG_WIDTH       = DEF_TAG_WIDTH,
  parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  localparam int IDX_W           = idx_width(NUM_REQS),
  localparam int CNT_W           = cnt_width(MAX_OUTSTANDING),
  localparam int BE_W            = DATA_WIDTH / 8,
  localparam int MTAG_W          = TAG_WIDTH + IDX_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS-1:0]            req_rw,
  input  logic [NUM_REQS*BE_W-1:0]       req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic [NUM_REQS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  input  logic [NUM_REQS-1:0]            rsp_ready,
  output logic                           mem_req_valid,
  output logic                           mem_req_rw,
  output logic [BE_W-1:0]                mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [DATA_WIDTH-1:0]          mem_req_data,
  output logic [MTAG_W-1:0]              mem_req_tag,
  input  logic                           mem_req_ready,
  input  logic                           mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
  input  logic [MTAG_W-1:0]              mem_rsp_tag,
  output logic                           mem_rsp_ready,
  output logic                           busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic                  rw;
    logic [BE_W-1:0]       byteen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [MTAG_W-1:0]     tag;
  } out_req_t;

  logic                  load_en_s;
  logic [NUM_REQS-1:0]   elig_s;
  logic [NUM_REQS-1:0]   grant_s;
  logic [IDX_W-1:0]      grant_idx_s;
  logic                  grant_any_s;
  out_req_t              out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_W-1:0]      cnt_q [NUM_REQS];
  logic [CNT_W-1:0]      cnt_d [NUM_REQS];
  logic [NUM_REQS-1:0]   inc_s, dec_s, cnt_zero_s;
  logic                  rsp_full_q, rsp_full_d;
  logic [IDX_W-1:0]      rsp_sel_q, rsp_sel_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic [IDX_W-1:0]      mem_rsp_idx_s;
  logic [NUM_REQS-1:0]   rsp_hit_s, rsp_valid_s;
  logic                  rsp_in_range_s, rsp_fire_s, mem_rsp_fire_s;

  // The output register can take a new request when empty or draining this cycle.
  always_comb begin
    load_en_s = !out_valid_q || mem_req_ready;
    for (int i = 0; i < NUM_REQS; i++) begin
      elig_s[i] = req_valid[i] && (req_rw[i] || (cnt_q[i] < CNT_MAX));
    end
  end

  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_rr (
    .clk_i       (clk),
    .rst_i       (reset),
    .valid_i     (elig_s),
    .advance_i   (load_en_s && !reset),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s),
    .grant_any_o (grant_any_s)
  );

  assign req_ready = grant_s & {NUM_REQS{load_en_s && !reset}};

  // Capture the granted request; the requester index rides in the tag MSBs.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (load_en_s) begin
      out_valid_d = grant_any_s;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (grant_s[i]) begin
          out_d.rw     = req_rw[i];
          out_d.byteen = req_byteen[i*BE_W +: BE_W];
          out_d.addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          out_d.data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
          out_d.tag    = {grant_idx_s, req_tag[i*TAG_WIDTH +: TAG_WIDTH]};
        end else begin
        end
      end
    end else begin
    end
  end

  // Request output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mem_req_valid  = out_valid_q;
  assign mem_req_rw     = out_q.rw;
  assign mem_req_byteen = out_q.byteen;
  assign mem_req_addr   = out_q.addr;
  assign mem_req_data   = out_q.data;
  assign mem_req_tag    = out_q.tag;

  // Decode the response index and the routing of the held response.
  always_comb begin
    mem_rsp_idx_s = mem_rsp_tag[MTAG_W-1 -: IDX_W];
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_hit_s[i]   = (mem_rsp_idx_s == IDX_W'(i));
      rsp_valid_s[i] = rsp_full_q && (rsp_sel_q == IDX_W'(i));
    end
    rsp_in_range_s = |rsp_hit_s;
    rsp_fire_s     = |(rsp_valid_s & rsp_ready);
    mem_rsp_ready  = (!rsp_full_q || rsp_fire_s) && !reset;
    mem_rsp_fire_s = mem_rsp_valid && mem_rsp_ready;
  end

  // Response register next state; out-of-range indices are consumed and dropped.
  always_comb begin
    rsp_full_d = rsp_full_q;
    rsp_sel_d  = rsp_sel_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    if (mem_rsp_fire_s) begin
      rsp_full_d = rsp_in_range_s;
      if (rsp_in_range_s) begin
        rsp_sel_d  = mem_rsp_idx_s;
        rsp_data_d = mem_rsp_data;
        rsp_tag_d  = mem_rsp_tag[TAG_WIDTH-1:0];
      end else begin
      end
    end else if (rsp_fire_s) begin
      rsp_full_d = 1'b0;
    end else begin
    end
  end

  // Response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_full_q <= 1'b0;
      rsp_sel_q  <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
    end else begin
      rsp_full_q <= rsp_full_d;
      rsp_sel_q  <= rsp_sel_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
    end
  end

  assign rsp_valid = rsp_valid_s;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;

  // Outstanding-read counters: granted reads count up, accepted responses count down.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      inc_s[i]      = req_ready[i] && !req_rw[i];
      dec_s[i]      = rsp_valid_s[i] && rsp_ready[i];
      cnt_zero_s[i] = (cnt_q[i] == '0);
      cnt_d[i]      = cnt_q[i];
      if (inc_s[i] && !dec_s[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_s[i] && !inc_s[i] && !cnt_zero_s[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end else begin
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy = out_valid_q || rsp_full_q || !(&cnt_zero_s);

  vx_local_mem_arbiter_chk #(.NUM_REQS(NUM_REQS), .REQ_W($bits(out_req_t))) u_chk (
    .clk_i              (clk),
    .rst_i              (reset),
    .mem_req_valid_i    (out_valid_q),
    .mem_req_ready_i    (mem_req_ready),
    .mem_req_bits_i     (out_q),
    .mem_rsp_fire_i     (mem_rsp_fire_s),
    .mem_rsp_in_range_i (rsp_in_range_s),
    .cnt_dec_i          (dec_s),
    .cnt_zero_i         (cnt_zero_s)
  );

endmodule

// File: tb/tb_vx_local_mem_arbiter.sv
// Randomized bench for vx_local_mem_arbiter with a transaction-level reference model.
module tb_vx_local_mem_arbiter;

  localparam int N    = 2;
  localparam int AW   = 26;
  localparam int DW   = 512;
  localparam int TW   = 56;
  localparam int MAXO = 8;
  localparam int BEW  = DW / 8;
  localparam int IW   = 1;
  localparam int MTW  = TW + IW;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
  logic [N*BEW-1:0] req_byteen;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic [DW-1:0]   rsp_data;
  logic [TW-1:0]   rsp_tag;
  logic            mem_req_valid, mem_req_rw, mem_req_ready;
  logic [BEW-1:0]  mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data, mem_rsp_data;
  logic [MTW-1:0]  mem_req_tag, mem_rsp_tag;
  logic            mem_rsp_valid, mem_rsp_ready, busy;

  vx_local_mem_arbiter #(
    .NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen), .req_addr(req_addr),
    .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the arbiter should hold after each clock.
  int              m_last;
  int              m_cnt [N];
  bit              m_out_valid;
  logic            m_out_rw;
  logic [BEW-1:0]  m_out_be;
  logic [AW-1:0]   m_out_addr;
  logic [DW-1:0]   m_out_data;
  logic [MTW-1:0]  m_out_tag;
  bit              m_rsp_full;
  int              m_rsp_sel;
  logic [DW-1:0]   m_rsp_data;
  logic [TW-1:0]   m_rsp_tag;
  // Memory model: reads accepted but not yet answered (answered in any order).
  logic [MTW-1:0]  pend_tag [$];
  int              rsp_pick;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_out_valid = 0; m_out_rw = 1'b0; m_out_be = '0; m_out_addr = '0;
    m_out_data = '0; m_out_tag = '0;
    m_rsp_full = 0; m_rsp_sel = 0; m_rsp_data = '0; m_rsp_tag = '0;
    pend_tag.delete();
    rsp_pick = -1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_rw = '0; req_byteen = '0; req_addr = '0; req_data = '0; req_tag = '0;
    rsp_ready = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
    rsp_pick = -1;
  endtask

  // Percent knobs: request valid, write share, memory ready, memory reply, requester rsp ready.
  task automatic drive(input int p_val, input int p_wr, input int p_mrdy, input int p_mrsp, input int p_rrdy);
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = ($urandom_range(99) < p_val);
      req_rw[i]    = ($urandom_range(99) < p_wr);
      v = rand_wide();
      req_addr[i*AW +: AW]    = v[AW-1:0];
      req_tag[i*TW +: TW]     = v[DW-1 -: TW];
      req_byteen[i*BEW +: BEW] = v[200 +: BEW];
      req_data[i*DW +: DW]    = rand_wide();
      rsp_ready[i] = ($urandom_range(99) < p_rrdy);
    end
    mem_req_ready = ($urandom_range(99) < p_mrdy);
    mem_rsp_data  = rand_wide();
    if (pend_tag.size() > 0 && $urandom_range(99) < p_mrsp) begin
      rsp_pick      = int'($urandom_range(pend_tag.size() - 1));
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = pend_tag[rsp_pick];
    end else begin
      rsp_pick      = -1;
      mem_rsp_valid = 1'b0;
      v = rand_wide();
      mem_rsp_tag   = v[MTW-1:0];
    end
  endtask

  // Compare DUT against the model for the current inputs, then advance the model one clock.
  task automatic eval_cycle();
    logic [N-1:0] exp_rr, exp_rv;
    bit load, fire, exp_mrr, exp_busy;
    int win, j;
    #1;
    load = !m_out_valid || mem_req_ready;
    win = -1;
    for (int off = 1; off <= N; off++) begin
      j = (m_last + off) % N;
      if (win < 0 && req_valid[j] && (req_rw[j] || m_cnt[j] < MAXO)) win = j;
    end
    exp_rr = '0;
    if (load && win >= 0) exp_rr[win] = 1'b1;
    exp_rv = '0;
    if (m_rsp_full) exp_rv[m_rsp_sel] = 1'b1;
    fire    = m_rsp_full && rsp_ready[m_rsp_sel];
    exp_mrr = !m_rsp_full || fire;
    exp_busy = m_out_valid || m_rsp_full;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) exp_busy = 1;

    check_eq("req_ready", req_ready, exp_rr);
    check_eq("mem_req_valid", mem_req_valid, m_out_valid);
    if (m_out_valid) begin
      check_eq("mem_req_tag", mem_req_tag, m_out_tag);
      check_eq("mem_req_addr", mem_req_addr, m_out_addr);
      check_eq("mem_req_rw", mem_req_rw, m_out_rw);
      check_eq("mem_req_data", mem_req_data, m_out_data);
      check_eq("mem_req_byteen", mem_req_byteen, m_out_be);
    end
    check_eq("rsp_valid", rsp_valid, exp_rv);
    if (m_rsp_full) begin
      check_eq("rsp_data", rsp_data, m_rsp_data);
      check_eq("rsp_tag", rsp_tag, m_rsp_tag);
    end
    check_eq("mem_rsp_ready", mem_rsp_ready, exp_mrr);
    check_eq("busy", busy, exp_busy);

    if (m_out_valid && mem_req_ready && !m_out_rw) pend_tag.push_back(m_out_tag);
    if (load && win >= 0 && !req_rw[win]) m_cnt[win]++;
    if (fire) m_cnt[m_rsp_sel]--;
    if (mem_rsp_valid && exp_mrr) begin
      pend_tag.delete(rsp_pick);
      m_rsp_full = 1;
      m_rsp_sel  = int'(mem_rsp_tag[MTW-1 -: IW]);
      m_rsp_data = mem_rsp_data;
      m_rsp_tag  = mem_rsp_tag[TW-1:0];
    end else if (fire) begin
      m_rsp_full = 0;
    end
    if (load) begin
      if (win >= 0) begin
        m_out_valid = 1;
        m_out_rw    = req_rw[win];
        m_out_be    = req_byteen[win*BEW +: BEW];
        m_out_addr  = req_addr[win*AW +: AW];
        m_out_data  = req_data[win*DW +: DW];
        m_out_tag   = {IW'(win), req_tag[win*TW +: TW]};
        m_last      = win;
      end else begin
        m_out_valid = 0;
      end
    end
  endtask

  task automatic run(input int cycles, input int p_val, input int p_wr, input int p_mrdy,
                     input int p_mrsp, input int p_rrdy);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      drive(p_val, p_wr, p_mrdy, p_mrsp, p_rrdy);
      eval_cycle();
    end
  endtask

  task automatic check_reset_outputs(input string sfx);
    check_eq({"rst_req_ready_", sfx}, req_ready, '0);
    check_eq({"rst_mem_req_valid_", sfx}, mem_req_valid, '0);
    check_eq({"rst_rsp_valid_", sfx}, rsp_valid, '0);
    check_eq({"rst_mem_rsp_ready_", sfx}, mem_rsp_ready, '0);
    check_eq({"rst_busy_", sfx}, busy, '0);
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    check_reset_outputs("init");
    check_eq("rst_mem_req_tag", mem_req_tag, '0);
    check_eq("rst_mem_req_data", mem_req_data, '0);
    check_eq("rst_rsp_data", rsp_data, '0);
    check_eq("rst_rsp_tag", rsp_tag, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single read from port 0, tag 0x5, addr 0x10, then let it complete.
    drive(0, 0, 100, 0, 100);
    req_valid[0] = 1'b1; req_rw[0] = 1'b0;
    req_addr[0 +: AW] = 26'h10; req_tag[0 +: TW] = 56'h5;
    mem_req_ready = 1'b1;
    eval_cycle();
    run(8, 0, 0, 100, 100, 100);

    // Saturating read traffic, memory stalls, caps, backpressure, mixed traffic.
    run(200, 100, 0, 100, 50, 100);
    run(200, 70, 30, 70, 60, 70);
    run(150, 80, 30, 80, 0, 100);
    run(150, 30, 40, 50, 80, 40);
    run(200, 90, 50, 60, 70, 60);

    // Reset with both the request and response registers occupied.
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      drive(90, 10, 40, 90, 20);
      eval_cycle();
      if (m_out_valid && m_rsp_full) found = 1;
    end
    check_eq("burst_state_reached", found, 1);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    check_reset_outputs("mid");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(100, 0, 100, 0, 100);
    eval_cycle();
    check_eq("first_grant_after_reset", req_ready, 2'b01);

    run(200, 60, 30, 70, 60, 70);
    run(80, 0, 0, 100, 100, 100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
